seg7_scan_rx: RTL



---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_decode.sv | 29 ++
 rtl/seg7_scan_rx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan receiver: active-low segment
// patterns (abcdefg, bit 6 = a), the illegal-digit code and the FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    localparam logic [3:0] BCD_ILLEGAL = 4'hF;

    typedef enum logic [1:0] {
        S_WAIT,
        S_STABLE,
        S_DONE
    } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-to-BCD decoder; anything that is not one of the ten
// digit patterns decodes to BCD_ILLEGAL with the illegal flag raised.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       illegal
);

    always_comb begin
        bcd     = BCD_ILLEGAL;
        illegal = 1'b0;
        case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_rx.sv
// Captures a multiplexed 7-segment scan bus: debounces each digit-select /
// segment pattern, decodes it, assembles a frame and offers it on valid/ready.
module seg7_scan_rx
    import seg7_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NDIG-1:0]   an,
    input  logic [6:0]        seg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NDIG-1:0] out_digits,
    output logic [NDIG-1:0]   out_err,
    output logic              overrun
);

    // Counter value on the edge before it would reach STABLE_CYC.
    localparam logic [7:0] CAP_CNT = 8'(STABLE_CYC - 1);

    logic [NDIG-1:0]   an_p0;
    logic [6:0]        seg_p0;
    logic              legal_p0;
    logic              match_p0;

    state_t            state;
    logic [7:0]        cnt;
    logic [NDIG-1:0]   cand_an;
    logic [6:0]        cand_seg;
    logic              capture;

    logic [3:0]        dec_bcd;
    logic              dec_illegal;

    logic [NDIG-1:0]   mask;
    logic              frame_full;
    logic [4*NDIG-1:0] stage_digits;
    logic [NDIG-1:0]   stage_err;

    // ---- stage p0: register the raw bus ----
    always_ff @(posedge clk) begin
        an_p0  <= an;
        seg_p0 <= seg;
    end

    assign legal_p0 = $onehot(~an_p0);
    assign match_p0 = (an_p0 == cand_an) && (seg_p0 == cand_seg);
    assign capture  = (state == S_STABLE) && match_p0 && (cnt == CAP_CNT);

    // ---- stage p1: stability FSM on the registered sample ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_WAIT;
            cnt   <= 8'd0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (legal_p0) begin
                        cand_an  <= an_p0;
                        cand_seg <= seg_p0;
                        cnt      <= 8'd1;
                        state    <= S_STABLE;
                    end
                end
                S_STABLE, S_DONE: begin
                    if (match_p0) begin
                        // S_DONE holds here so a steady pattern is captured once.
                        if (state == S_STABLE) begin
                            cnt <= cnt + 8'd1;
                            if (capture)
                                state <= S_DONE;
                        end
                    end else if (legal_p0) begin
                        cand_an  <= an_p0;
                        cand_seg <= seg_p0;
                        cnt      <= 8'd1;
                        state    <= S_STABLE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    seg7_decode u_decode (
        .seg     (cand_seg),
        .bcd     (dec_bcd),
        .illegal (dec_illegal)
    );

    // ---- stage p2: per-position staging and capture mask ----
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < NDIG; i++) begin
                if (!cand_an[i]) begin
                    stage_digits[4*i +: 4] <= dec_bcd;
                    stage_err[i]           <= dec_illegal;
                end
            end
        end
    end

    assign frame_full = &mask;

    always_ff @(posedge clk) begin
        if (rst)
            mask <= '0;
        else if (frame_full)
            mask <= '0;
        else if (capture)
            mask <= mask | ~cand_an;
    end

    // ---- stage p3: output frame register and handshake ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_digits <= '0;
            out_err    <= '0;
            overrun    <= 1'b0;
        end else if (frame_full) begin
            if (!out_valid || out_ready) begin
                out_digits <= stage_digits;
                out_err    <= stage_err;
                out_valid  <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
